spi_dac_sequencer: RTL

Command sequencer that sits directly upstream of the generic `Spi` master and drives the LTC2624 quad 12-bit DAC on the board.
- Accepts channel/value write requests over a valid/ready handshake and buffers them in a small FIFO.
- Formats each request into the 32-bit DAC command word and triggers one SPI transfer per word.
- Waits for `spi_done`, captures the word shifted back on MISO, then enforces a minimum chip-select-high gap before the next transfer.

---
 rtl/spi_dac_sequencer_if.sv | 22 ++
 rtl/spi_dac_sequencer.sv | 109 ++++++++++
 2 files changed

// File: rtl/spi_dac_sequencer_if.sv
// Request handshake plus the SPI-master connection used by spi_dac_sequencer.
// The "slave" modport is the sequencer side. The "master" modport is the requester/Spi side.
interface spi_dac_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_chan;
   logic [11:0] req_value;
   logic [31:0] spi_word;
   logic        spi_trig;
   logic        spi_done;
   logic [31:0] spi_rdata;

   modport slave (
      input  req_valid, req_chan, req_value, spi_done, spi_rdata,
      output req_ready, spi_word, spi_trig
   );

   modport master (
      output req_valid, req_chan, req_value, spi_done, spi_rdata,
      input  req_ready, spi_word, spi_trig
   );
endinterface

// File: rtl/spi_dac_sequencer.sv
// LTC2624 command sequencer: buffers channel/value writes, formats 32-bit DAC words,
// fires one Spi transfer per word and enforces a CS-high gap after each spi_done.
module spi_dac_sequencer #(
   parameter int         DEPTH = 4,
   parameter int         GAP   = 2,
   parameter logic [3:0] CMD   = 4'b0011
) (
   input  logic                     CLK50MHZ,
   input  logic                     RST,
   spi_dac_sequencer_if.slave       bus,
   output logic [31:0]              echo,
   output logic                     echo_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_GAP} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic [31:0]     word_q, word_d;
   logic [31:0]     echo_q, echo_d;
   logic            ev_q, ev_d;
   logic [GW-1:0]   gap_q, gap_d;
   logic [31:0]     fifo_q [DEPTH];
   logic            push, pop;

   assign bus.req_ready = (count_q != CW'(DEPTH));
   assign push          = bus.req_valid && bus.req_ready;

   // Words are stored pre-formatted so the pop path is a plain read.
   always_ff @(posedge CLK50MHZ) begin
      if (push) fifo_q[wr_ptr_q] <= {8'h00, CMD, bus.req_chan, bus.req_value, 4'h0};
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      echo_d  = echo_q;
      ev_d    = 1'b0;
      gap_d   = gap_q;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (count_q != '0) begin
               word_d  = fifo_q[rd_ptr_q];
               pop     = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.spi_done) begin
               echo_d  = bus.spi_rdata;
               ev_d    = 1'b1;
               gap_d   = GW'(GAP - 1);
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_q == '0) state_d = ST_IDLE;
            else             gap_d   = gap_q - GW'(1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge CLK50MHZ) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         word_q   <= '0;
         echo_q   <= '0;
         ev_q     <= 1'b0;
         gap_q    <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         word_q   <= word_d;
         echo_q   <= echo_d;
         ev_q     <= ev_d;
         gap_q    <= gap_d;
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   assign bus.spi_trig = (state_q == ST_LOAD);
   assign bus.spi_word = word_q;
   assign echo         = echo_q;
   assign echo_valid   = ev_q;
   assign count        = count_q;
   assign busy         = (state_q != ST_IDLE) || (count_q != '0);
endmodule
